// File: rtl/game_sequencer.sv
// game_sequencer: idle/play/hit/over sequencing, move arbitration, score/lives, tone scheduling; GAME_SEQ_RR_EN selects round-robin arbitration.
// Latency: all outputs registered, one clk after the causing event.
// Backpressure: none; dEnable=0 pauses tick-driven activity only.
module game_sequencer #(
  parameter int LIVES     = 3,
  parameter int HIT_TICKS = 16,
  parameter int SND_TICKS = 4,
  parameter int SCORE_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic [3:0]         btns,
  input  logic               up_en,
  input  logic               down_en,
  input  logic               left_en,
  input  logic               right_en,
  input  logic               collect,
  input  logic               hit,
  input  logic               modeSelect,
  input  logic               dEnable,
  output logic [3:0]         move,
  output logic [1:0]         state,
  output logic [SCORE_W-1:0] score,
  output logic [1:0]         lives,
  output logic [2:0]         snd_sel,
  output logic               snd_en,
  output logic               display_en
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_PLAY = 2'd1, S_HIT = 2'd2, S_OVER = 2'd3} state_t;

  localparam logic [7:0] HIT_LAST = 8'(HIT_TICKS - 1);
  localparam logic [7:0] SND_LAST = 8'(SND_TICKS - 1);

  state_t     cur;
  logic       modePrev;
  logic [7:0] hitCnt;
  logic [7:0] sndCnt;
  logic [3:0] cand;
  logic [3:0] grant;
  logic       start;
  logic       tickEn;
  logic       moveOk;

  assign state  = cur;
  assign start  = modeSelect & ~modePrev;
  assign tickEn = tick & dEnable;
  // A hit in the same cycle as a tick pre-empts the move.
  assign moveOk = (cur == S_PLAY) && tickEn && !hit;
  assign cand   = btns & {up_en, down_en, right_en, left_en};

`ifdef GAME_SEQ_RR_EN
  logic [1:0] rrPtr;
  logic [1:0] grantIdx;
  logic [1:0] idx;
  logic       found;

  // Index 0..3 = up, down, right, left, i.e. bit 3-index of cand.
  always_comb begin
    grant    = '0;
    grantIdx = rrPtr;
    idx      = rrPtr;
    found    = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idx = rrPtr + 2'(k);
      if (!found && cand[2'd3 - idx]) begin
        found              = 1'b1;
        grant[2'd3 - idx]  = 1'b1;
        grantIdx           = idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                   rrPtr <= 2'd0;
    else if (moveOk && |grant)  rrPtr <= grantIdx + 2'd1;
  end
`else
  always_comb begin
    grant = '0;
    if      (cand[3]) grant = 4'b1000;
    else if (cand[2]) grant = 4'b0100;
    else if (cand[1]) grant = 4'b0010;
    else if (cand[0]) grant = 4'b0001;
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur        <= S_IDLE;
      modePrev   <= 1'b1;
      hitCnt     <= '0;
      sndCnt     <= '0;
      move       <= '0;
      score      <= '0;
      lives      <= '0;
      snd_sel    <= '0;
      snd_en     <= 1'b0;
      display_en <= 1'b0;
    end else begin
      modePrev   <= modeSelect;
      display_en <= dEnable;
      move       <= moveOk ? grant : 4'b0000;

      if (snd_en && tickEn) begin
        if (sndCnt == SND_LAST) begin
          snd_en <= 1'b0;
          sndCnt <= '0;
        end else begin
          sndCnt <= sndCnt + 8'd1;
        end
      end

      case (cur)
        S_IDLE: begin
          if (start) begin
            score <= '0;
            lives <= 2'(LIVES);
            cur   <= S_PLAY;
          end
        end
        S_PLAY: begin
          if (collect) begin
            if (score != '1) score <= score + SCORE_W'(1);
            snd_sel <= 3'd1;
            snd_en  <= 1'b1;
            sndCnt  <= '0;
          end
          // Hit overrides the collect tone when both arrive together.
          if (hit) begin
            lives  <= lives - 2'd1;
            snd_en <= 1'b1;
            sndCnt <= '0;
            if (lives == 2'd1) begin
              cur     <= S_OVER;
              snd_sel <= 3'd3;
            end else begin
              cur     <= S_HIT;
              hitCnt  <= '0;
              snd_sel <= 3'd2;
            end
          end
        end
        S_HIT: begin
          if (tickEn) begin
            if (hitCnt == HIT_LAST) begin
              cur    <= S_PLAY;
              hitCnt <= '0;
            end else begin
              hitCnt <= hitCnt + 8'd1;
            end
          end
        end
        S_OVER: begin
          if (start) cur <= S_IDLE;
        end
        default: cur <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer in its default (fixed-priority) build.
module tb_game_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic [3:0] btns;
  logic       up_en, down_en, left_en, right_en;
  logic       collect, hit, modeSelect, dEnable;
  logic [3:0] move;
  logic [1:0] state;
  logic [7:0] score;
  logic [1:0] lives;
  logic [2:0] snd_sel;
  logic       snd_en;
  logic       display_en;

  int checks = 0;
  int passes = 0;
  int fails  = 0;
  logic [3:0] moveOr;
  logic [3:0] lastMove;

  game_sequencer dut (
    .clk(clk), .rst(rst), .tick(tick), .btns(btns),
    .up_en(up_en), .down_en(down_en), .left_en(left_en), .right_en(right_en),
    .collect(collect), .hit(hit), .modeSelect(modeSelect), .dEnable(dEnable),
    .move(move), .state(state), .score(score), .lives(lives),
    .snd_sel(snd_sel), .snd_en(snd_en), .display_en(display_en)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic tickPulse();
    tick = 1'b1;
    cyc();
    lastMove = move;
    moveOr   = moveOr | move;
    tick = 1'b0;
    cyc();
  endtask

  task automatic startEdge();
    modeSelect = 1'b0;
    cyc();
    modeSelect = 1'b1;
    cyc();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0; tick = 1'b0; btns = 4'b0000;
    up_en = 1'b1; down_en = 1'b1; left_en = 1'b1; right_en = 1'b1;
    collect = 1'b0; hit = 1'b0; modeSelect = 1'b1; dEnable = 1'b1;
    moveOr = '0; lastMove = '0;
    #12;
    chk("rst_state", state, 0);
    chk("rst_move", move, 0);
    chk("rst_score", score, 0);
    chk("rst_lives", lives, 0);
    chk("rst_snd_sel", snd_sel, 0);
    chk("rst_snd_en", snd_en, 0);
    chk("rst_display_en", display_en, 0);

    // Switch held high through reset must not start the game.
    @(posedge clk); #1; rst = 1'b1;
    cyc(); cyc();
    chk("held_switch_no_start", state, 0);
    chk("display_en_follows", display_en, 1);

    startEdge();
    chk("start_state", state, 1);
    chk("start_lives", lives, 3);
    chk("start_score", score, 0);
    cyc(); cyc(); cyc();
    chk("hold_no_retrigger", state, 1);

    // Arbitration.
    btns = 4'b1010;
    tickPulse();
    chk("move_up", lastMove, 4'b1000);
    chk("move_one_cycle", move, 0);
    up_en = 1'b0;
    tickPulse();
    chk("move_right_upblocked", lastMove, 4'b0010);
    up_en = 1'b1;
    btns = 4'b0000;
    tickPulse();
    chk("move_empty", lastMove, 0);
    btns = 4'b0001;
    tickPulse();
    chk("move_left", lastMove, 4'b0001);
    btns = 4'b0111;
    tickPulse();
    chk("move_down_prio", lastMove, 4'b0100);
    dEnable = 1'b0;
    tickPulse();
    chk("paused_no_move", lastMove, 0);
    chk("paused_display_en", display_en, 0);
    dEnable = 1'b1;
    btns = 4'b0000;

    // Collect and tone hold.
    collect = 1'b1; cyc(); collect = 1'b0;
    chk("collect_score", score, 1);
    chk("collect_snd_sel", snd_sel, 1);
    chk("collect_snd_en", snd_en, 1);
    tickPulse(); tickPulse(); tickPulse();
    chk("snd_en_after_3_ticks", snd_en, 1);
    tickPulse();
    chk("snd_en_after_4_ticks", snd_en, 0);
    chk("snd_sel_kept", snd_sel, 1);

    collect = 1'b1;
    for (int i = 0; i < 253; i++) cyc();
    chk("score_254", score, 254);
    for (int i = 0; i < 46; i++) cyc();
    collect = 1'b0;
    chk("score_saturated", score, 255);

    // Hit coincident with a tick: hit wins, no move.
    btns = 4'b1000;
    hit = 1'b1; tick = 1'b1; cyc(); hit = 1'b0; tick = 1'b0;
    chk("hit_tick_no_move", move, 0);
    chk("hit1_lives", lives, 2);
    chk("hit1_state", state, 2);
    chk("hit1_snd_sel", snd_sel, 2);
    chk("hit1_snd_en", snd_en, 1);
    cyc();
    moveOr = '0;
    for (int i = 0; i < 5; i++) tickPulse();
    hit = 1'b1; cyc(); hit = 1'b0;
    chk("hit_ignored_in_hit", lives, 2);
    dEnable = 1'b0;
    for (int i = 0; i < 3; i++) tickPulse();
    chk("pause_display_en", display_en, 0);
    chk("pause_hold_state", state, 2);
    dEnable = 1'b1;
    for (int i = 0; i < 10; i++) tickPulse();
    chk("hit_15_ticks", state, 2);
    tickPulse();
    chk("hit_16_ticks_play", state, 1);
    chk("hit_no_moves", moveOr, 0);
    tickPulse();
    chk("move_after_hit", lastMove, 4'b1000);

    hit = 1'b1; cyc(); hit = 1'b0;
    chk("hit2_lives", lives, 1);
    chk("hit2_state", state, 2);
    for (int i = 0; i < 16; i++) tickPulse();
    chk("hit2_back_play", state, 1);
    hit = 1'b1; cyc(); hit = 1'b0;
    chk("hit3_state_over", state, 3);
    chk("hit3_snd_sel", snd_sel, 3);
    chk("hit3_lives", lives, 0);
    moveOr = '0;
    tickPulse();
    chk("over_no_move", moveOr, 0);
    chk("over_score_holds", score, 255);

    startEdge();
    chk("over_to_idle", state, 0);
    chk("idle_score_holds", score, 255);
    startEdge();
    chk("restart_state", state, 1);
    chk("restart_score", score, 0);
    chk("restart_lives", lives, 3);

    // Hit and collect together.
    hit = 1'b1; collect = 1'b1; cyc(); hit = 1'b0; collect = 1'b0;
    chk("both_score", score, 1);
    chk("both_snd_sel", snd_sel, 2);
    chk("both_lives", lives, 2);
    for (int i = 0; i < 16; i++) tickPulse();
    chk("both_back_play", state, 1);

    // Asynchronous reset mid-play.
    btns = 4'b1000;
    collect = 1'b1; tick = 1'b1; cyc(); collect = 1'b0; tick = 1'b0;
    chk("pre_rst_move", move, 4'b1000);
    chk("pre_rst_snd_en", snd_en, 1);
    #1 rst = 1'b0;
    #1;
    chk("arst_move", move, 0);
    chk("arst_snd_en", snd_en, 0);
    chk("arst_state", state, 0);
    chk("arst_score", score, 0);
    chk("arst_lives", lives, 0);
    chk("arst_snd_sel", snd_sel, 0);
    chk("arst_display_en", display_en, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
